// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//
// Packs decoded instruction fields back into 32-bit RV32I words. This is the
// inverse of the immediate generator. It feeds the program loader and the
// self-test writer that fill instruction memory.
//
// Every immediate is range-checked for its format. A request that cannot be
// encoded still produces a word: the word is the canonical NOP
// (addi x0,x0,0 = 32'h0000_0013), with out_err raised. That word still
// occupies an address, so later words stay at their intended locations.
//
// The output is a single registered entry with a valid/ready handshake on
// both sides. The input can be accepted in the same cycle the held word
// drains, so the block sustains one word per cycle.
//
// Parameters
//   ADDR_W     width of out_addr
//   BASE_ADDR  byte address of the first word after reset/restart (4-aligned)
//
// Ports
//   clk         clock, all state on rising edge
//   reset       synchronous, active-high; overrides everything
//   restart     pulse: drop held word, reload BASE_ADDR, clear counters
//   in_valid    request valid
//   in_ready    request accepted when in_valid && in_ready
//   in_fmt      0=I 1=S 2=B 3=J 4=U 5=SHIFT, 6/7 illegal
//   in_opcode   opcode  -> [6:0]
//   in_rd       rd      -> [11:7]   (I, J, U, SHIFT)
//   in_rs1      rs1     -> [19:15]  (I, S, B, SHIFT)
//   in_rs2      rs2     -> [24:20]  (S, B)
//   in_funct3   funct3  -> [14:12]  (I, S, B, SHIFT)
//   in_funct7   funct7  -> [31:25]  (SHIFT only)
//   in_imm      signed immediate / byte offset
//   out_valid   held word valid
//   out_ready   consumer accepts when out_valid && out_ready
//   out_inst    encoded word
//   out_addr    byte address of out_inst
//   out_err     out_inst is a substituted NOP
//   word_count  words handed off (wraps)
//   err_count   errored words handed off (saturates at 255)
// ---------------------------------------------------------------------------
module inst_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       word_count,
  output logic [7:0]        err_count
);

  // Format codes on in_fmt.
  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_S     = 3'd1;
  localparam logic [2:0] FMT_B     = 3'd2;
  localparam logic [2:0] FMT_J     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_SHIFT = 3'd5;

  // addi x0, x0, 0: substituted for any word that cannot be encoded.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  // -------------------------------------------------------------------------
  // Range helper
  // -------------------------------------------------------------------------
  // Returns true when v, read as a signed 32-bit value, lies in
  // -2^msb .. 2^msb-1. That holds exactly when bits [31:msb] are all copies
  // of the sign bit. An arithmetic shift by msb then leaves all-zeros or
  // all-ones.
  function automatic logic fits_signed(input logic [31:0] v, input int msb);
    logic [31:0] t;
    t = 32'($signed(v) >>> msb);
    return (t == '0) || (t == '1);
  endfunction

  // -------------------------------------------------------------------------
  // Combinational encoder
  // -------------------------------------------------------------------------
  logic [31:0] enc_inst;
  logic        enc_err;

  // Legality flags for each format, kept separate from the packing logic.
  logic ok_i, ok_s, ok_b, ok_j, ok_u, ok_shift;

  assign ok_i     = fits_signed(in_imm, 11);
  assign ok_s     = fits_signed(in_imm, 11);
  // B and J offsets address 2-byte units. Bit 0 is not encodable, so it
  // must be clear. The positive limit is therefore one below 2^msb-1.
  assign ok_b     = fits_signed(in_imm, 12) && !in_imm[0];
  assign ok_j     = fits_signed(in_imm, 20) && !in_imm[0];
  // U carries only the upper 20 bits. Any low bit set would be silently lost.
  assign ok_u     = (in_imm[11:0] == 12'd0);
  // The shift amount is an unsigned 5-bit field.
  assign ok_shift = (in_imm[31:5] == 27'd0);

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    enc_inst = NOP_INST;
    enc_err  = 1'b1;
    case (in_fmt)
      FMT_I: begin
        if (ok_i) begin
          enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err  = 1'b0;
        end
      end
      FMT_S: begin
        if (ok_s) begin
          enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:0], in_opcode};
          enc_err  = 1'b0;
        end
      end
      FMT_B: begin
        if (ok_b) begin
          enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
          enc_err  = 1'b0;
        end
      end
      FMT_J: begin
        if (ok_j) begin
          enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                      in_rd, in_opcode};
          enc_err  = 1'b0;
        end
      end
      FMT_U: begin
        if (ok_u) begin
          enc_inst = {in_imm[31:12], in_rd, in_opcode};
          enc_err  = 1'b0;
        end
      end
      FMT_SHIFT: begin
        if (ok_shift) begin
          enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd,
                      in_opcode};
          enc_err  = 1'b0;
        end
      end
      default: begin
        // Formats 6 and 7 have no encoding; keep the NOP and the error.
        enc_inst = NOP_INST;
        enc_err  = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  // in_ready does not look at in_valid. An upstream that waits for ready
  // before asserting valid therefore cannot deadlock against this block.
  // The slot is free when it is empty, or when the held word leaves in
  // this cycle.
  assign in_ready = !reset && !restart && (!out_valid || out_ready);

  logic in_hs;
  logic out_hs;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // -------------------------------------------------------------------------
  // Output register, address and counters
  // -------------------------------------------------------------------------
  // out_addr always holds BASE_ADDR + 4 * (words handed off since reset or
  // restart). The held word therefore owns out_addr. A word accepted in the
  // same cycle as a hand-off lands on the incremented address.
  //
  // NOTE: all state here uses non-blocking assignments. Every read in this
  // block then sees the pre-edge value, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_err    <= 1'b0;
      out_addr   <= BASE_ADDR;
      word_count <= '0;
      err_count  <= '0;
    end else if (restart) begin
      // A held word is dropped uncounted, even if the consumer takes it in
      // this same cycle. in_ready is low, so nothing new enters.
      out_valid  <= 1'b0;
      out_addr   <= BASE_ADDR;
      word_count <= '0;
      err_count  <= '0;
    end else begin
      if (out_hs) begin
        out_addr   <= out_addr + WORD_BYTES;
        word_count <= word_count + 16'd1;
        if (out_err && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end

      if (in_hs) begin
        out_valid <= 1'b1;
        out_inst  <= enc_inst;
        out_err   <= enc_err;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;

  logic        clk = 1'b0;
  logic        reset, restart;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] word_count;
  logic [7:0]  err_count;

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err),
    .word_count(word_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Encoding from the ISA field definitions, using integer range arithmetic.
  function automatic logic [32:0] model_encode(input int fmt, input int op, input int rd,
                                               input int rs1, input int rs2, input int f3,
                                               input int f7, input int imm);
    longint v;
    logic [31:0] w;
    v = longint'(imm);
    w = 32'h13;
    case (fmt)
      0: if (v >= -2048 && v <= 2047)
           return {1'b0, 32'((v & 'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op)};
      1: if (v >= -2048 && v <= 2047)
           return {1'b0, 32'(((v >> 5) & 'h7F) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 |
                             (v & 'h1F) << 7 | op)};
      2: if (v >= -4096 && v <= 4094 && (v % 2) == 0)
           return {1'b0, 32'(((v >> 12) & 1) << 31 | ((v >> 5) & 'h3F) << 25 | rs2 << 20 |
                             rs1 << 15 | f3 << 12 | ((v >> 1) & 'hF) << 8 |
                             ((v >> 11) & 1) << 7 | op)};
      3: if (v >= -1048576 && v <= 1048574 && (v % 2) == 0)
           return {1'b0, 32'(((v >> 20) & 1) << 31 | ((v >> 1) & 'h3FF) << 21 |
                             ((v >> 11) & 1) << 20 | ((v >> 12) & 'hFF) << 12 |
                             rd << 7 | op)};
      4: if ((v & 'hFFF) == 0)
           return {1'b0, 32'((v & 'hFFFF_F000) | rd << 7 | op)};
      5: if (v >= 0 && v <= 31)
           return {1'b0, 32'(f7 << 25 | v << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op)};
      default: ;
    endcase
    return {1'b1, w};
  endfunction

  logic        m_valid = 1'b0, m_err = 1'b0;
  logic [31:0] m_inst = '0, m_addr = BASE;
  int          m_wc = 0, m_ec = 0;

  function automatic logic m_ready();
    return !reset && !restart && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    logic [32:0] e;
    logic hs, acc;
    if (reset) begin
      m_valid = 0; m_inst = 0; m_err = 0; m_addr = BASE; m_wc = 0; m_ec = 0;
    end else if (restart) begin
      m_valid = 0; m_addr = BASE; m_wc = 0; m_ec = 0;
    end else begin
      hs  = m_valid && out_ready;
      acc = in_valid && m_ready();
      if (hs) begin
        m_addr = m_addr + 4;
        m_wc   = (m_wc + 1) % 65536;
        if (m_err && m_ec < 255) m_ec = m_ec + 1;
      end
      if (acc) begin
        e = model_encode(int'(in_fmt), int'(in_opcode), int'(in_rd), int'(in_rs1),
                         int'(in_rs2), int'(in_funct3), int'(in_funct7), int'(in_imm));
        m_valid = 1; m_err = e[32]; m_inst = e[31:0];
      end else if (hs) begin
        m_valid = 0;
      end
    end
  end

  // One compare process, on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", 32'(in_ready), 32'(m_ready()));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("out_inst", out_inst, m_inst);
        check("out_addr", out_addr, m_addr);
        check("out_err", 32'(out_err), 32'(m_err));
      end
      check("word_count", 32'(word_count), 32'(m_wc));
      check("err_count", 32'(err_count), 32'(m_ec));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int  guard = 0;
    bit  ok = 1'b0;
    in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    while (!ok && guard < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", guard);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
  } bvec_t;

  bvec_t bounds[14];

  initial begin
    time t0;
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;

    // Reset state.
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_counts", {8'(0), err_count, word_count}, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cmp_en = 1'b1;

    // Known encodings, addresses 0,4,8,C.
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    check("lit_I", out_inst, 32'h0050_0093);
    check("lit_I_addr", out_addr, 32'h0);
    check("lit_I_err", 32'(out_err), 32'd0);
    send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8);
    check("lit_B", out_inst, 32'hFE20_8CE3);
    check("lit_B_addr", out_addr, 32'h4);
    send(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    check("lit_J", out_inst, 32'h0010_00EF);
    send(3'd5, 7'h13, 5'd3, 5'd3, 5'd0, 3'd5, 7'h20, 32'd4);
    check("lit_SHIFT", out_inst, 32'h4041_D193);
    check("lit_SHIFT_addr", out_addr, 32'hC);
    @(posedge clk); #1;

    // Error words.
    pulse_restart();
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    check("lit_err1_inst", out_inst, 32'h0000_0013);
    check("lit_err1_flag", 32'(out_err), 32'd1);
    check("lit_err1_addr", out_addr, 32'h0);
    send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    check("lit_err2_inst", out_inst, 32'h0000_0013);
    check("lit_err2_addr", out_addr, 32'h4);
    @(posedge clk); #1;
    check("lit_err_count", 32'(err_count), 32'd2);

    // Backpressure: hold a U word while a new request waits 5 cycles.
    out_ready = 1'b0;
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    in_valid = 1'b1; in_fmt = 3'd0; in_opcode = 7'h13; in_rd = 5'd2; in_rs1 = 5'd2;
    in_funct3 = 3'd0; in_imm = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lit_bp_ready", 32'(in_ready), 32'd0);
      check("lit_bp_inst", out_inst, 32'h1234_52B7);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    t0 = $time;
    send(3'd0, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    check("lit_I_neg", out_inst, 32'hFFF1_0113);
    send(3'd1, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, -32'sd4);
    send(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    check("lit_throughput_ns", 32'($time - t0), 32'd30);
    @(posedge clk); #1;

    // Range boundaries, checked by the model.
    bounds = '{
      '{3'd0, -32'sd2048}, '{3'd0, 32'd2047}, '{3'd0, -32'sd2049},
      '{3'd1, 32'd2047},   '{3'd1, 32'd2048},
      '{3'd2, 32'd4094},   '{3'd2, -32'sd4096}, '{3'd2, 32'd4096},
      '{3'd3, -32'sd1048576}, '{3'd3, 32'd1048574}, '{3'd3, 32'd7},
      '{3'd4, 32'hFFFF_F001}, '{3'd5, 32'd31},  '{3'd5, 32'd32}
    };
    foreach (bounds[i])
      send(bounds[i].fmt, 7'h33, 5'd7, 5'd9, 5'd11, 3'd3, 7'h01, bounds[i].imm);
    @(posedge clk); #1;

    // Restart with a held word at address 8, consumer ready.
    pulse_restart();
    send(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
    send(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2);
    send(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd3);
    check("lit_pre_rs_addr", out_addr, 32'h8);
    check("lit_pre_rs_valid", 32'(out_valid), 32'd1);
    pulse_restart();
    check("lit_rs_valid", 32'(out_valid), 32'd0);
    check("lit_rs_addr", out_addr, BASE);
    check("lit_rs_wc", 32'(word_count), 32'd0);

    // err_count saturation.
    for (int i = 0; i < 260; i++)
      send(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(posedge clk); #1;
    check("lit_ec_sat", 32'(err_count), 32'd255);
    check("lit_wc_260", 32'(word_count), 32'd260);

    // Reset in the middle of a stall.
    out_ready = 1'b0;
    send(3'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("lit_stall_rst_valid", 32'(out_valid), 32'd0);
    check("lit_stall_rst_addr", out_addr, BASE);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
